cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous active-high reset); all state SHALL update only on posedge clk.
REQ-002 The block SHALL have input en (1): mtc0 write enable from M stage.
REQ-003 The block SHALL have input CP0Add (5): register index for read and write.
REQ-004 The block SHALL have input CP0In (32): mtc0 write data.
REQ-005 The block SHALL have input VPC (32): PC of the M-stage instruction, taken from the M pipeline register.
REQ-006 The block SHALL have input BDIn (1): the M-stage instruction sits in a delay slot.
REQ-007 The block SHALL have input ExcCodeIn (5): M-stage exception code; 0 means no exception.
REQ-008 The block SHALL have input HWInt (6): external interrupt lines.
REQ-009 The block SHALL have input EXLClr (1): eret in M stage.
REQ-010 The block SHALL have output CP0Out (32): combinational read data.
REQ-011 The block SHALL have output EPCOut (32): current EPC.
REQ-012 The block SHALL have output Req (1): combinational flush/redirect request to all pipeline registers and the PC (vector 0x4180).

Function
REQ-013 The block SHALL implement SR (index 12), Cause (index 13) and EPC (index 14); all other indices SHALL read 0 and ignore writes.
REQ-014 SR SHALL hold IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-015 Cause SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-016 IntReq SHALL be defined as (|(HWInt & SR.IM)) & SR.IE & !SR.EXL.
REQ-017 ExcReq SHALL be defined as (ExcCodeIn != 0) & !SR.EXL.
REQ-018 Req SHALL equal IntReq | ExcReq, combinationally, in the same cycle as its inputs.
REQ-019 On a clock with Req=1, the block SHALL set EXL to 1 and BD to BDIn.
REQ-020 On a clock with Req=1, ExcCode SHALL load 0 if IntReq=1 (interrupt wins over a simultaneous exception), else ExcCodeIn.
REQ-021 On a clock with Req=1, EPC SHALL load BDIn ? VPC-4 : VPC, computed with 32-bit wrap and bits [1:0] forced to 0.
REQ-022 Cause.IP SHALL load HWInt on every non-reset clock, independent of Req and en.
REQ-023 On a clock with EXLClr=1 and Req=0, the block SHALL clear EXL to 0.
REQ-024 On a clock with en=1 and Req=0, the block SHALL write CP0In to the register at CP0Add; SR takes only IM/EXL/IE bits, EPC takes CP0In with bits [1:0] forced to 0.
REQ-025 Priority SHALL be Req > EXLClr > en for EXL; if EXLClr and an mtc0 to SR coincide with Req=0, EXL SHALL end 0 and IM/IE SHALL take CP0In.
REQ-026 CP0Out SHALL reflect the register values before the current edge; a write is visible on the next cycle.
REQ-027 EPCOut SHALL always equal the EPC register.

Reset
REQ-028 On a clock with reset=1, SR, Cause and EPC SHALL all become 0, so Req=0 until the next clock.
REQ-029 reset SHALL take priority over Req, EXLClr and en on the same edge.

Verification
REQ-030 The bench SHALL cover: reset, then read CP0Add=12/13/14 -> CP0Out=0 for each; Req=0.
REQ-031 The bench SHALL cover: mtc0 SR=0x0000FC01, then HWInt=6'b000100 -> Req=1 the same cycle; after the edge, Cause=0x00001000 with ExcCode=0, EXL=1, EPC=VPC.
REQ-032 The bench SHALL cover: ExcCodeIn=5'd12, BDIn=1, VPC=0x3008, EXL=0 -> Req=1; after the edge, EPC=0x3004, Cause.BD=1, Cause.ExcCode=12.
REQ-033 The bench SHALL cover: EXL=1 with ExcCodeIn=4 and an enabled HWInt -> Req=0; the registers keep their values except Cause.IP.
REQ-034 The bench SHALL cover: EXLClr=1 -> EXL=0 next cycle; an interrupt still pending then raises Req on that next cycle.
REQ-035 The bench SHALL cover: reset=1 asserted together with ExcCodeIn=4 and en=1 -> after the edge all registers=0.

Source files
------------

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bus: mtc0/mfc0 access, exception inputs and flush/redirect outputs.
// The master modport is the pipeline side; the slave modport is the coprocessor.
interface cp0_unit_if;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 holding SR, Cause and EPC, with interrupt/exception entry and eret.
// Req is combinational so the pipeline can flush in the same cycle as the cause.
module cp0_unit (
  input  logic         clk,
  input  logic         reset,
  cp0_unit_if.slave    bus
);
  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;

  logic [5:0]  sr_im_reg;
  logic        sr_exl_reg;
  logic        sr_ie_reg;
  logic        cause_bd_reg;
  logic [5:0]  cause_ip_reg;
  logic [4:0]  cause_exc_reg;
  logic [31:0] epc_reg;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd_data;

  assign sr_val    = {16'd0, sr_im_reg, 8'd0, sr_exl_reg, sr_ie_reg};
  assign cause_val = {cause_bd_reg, 15'd0, cause_ip_reg, 3'd0, cause_exc_reg, 2'd0};

  assign int_req  = (|(bus.HWInt & sr_im_reg)) & sr_ie_reg & ~sr_exl_reg;
  assign exc_req  = (bus.ExcCodeIn != 5'd0) & ~sr_exl_reg;
  assign req      = int_req | exc_req;

  // Delay-slot victims restart at the branch, one word earlier.
  assign epc_next = (bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC) & 32'hFFFF_FFFC;

  always_comb begin
    rd_data = 32'd0;
    case (bus.CP0Add)
      IDX_SR:    rd_data = sr_val;
      IDX_CAUSE: rd_data = cause_val;
      IDX_EPC:   rd_data = epc_reg;
      default:   rd_data = 32'd0;
    endcase
  end

  assign bus.CP0Out = rd_data;
  assign bus.EPCOut = epc_reg;
  assign bus.Req    = req;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_reg     <= 6'd0;
      sr_exl_reg    <= 1'b0;
      sr_ie_reg     <= 1'b0;
      cause_bd_reg  <= 1'b0;
      cause_ip_reg  <= 6'd0;
      cause_exc_reg <= 5'd0;
      epc_reg       <= 32'd0;
    end else begin
      cause_ip_reg <= bus.HWInt;
      if (req) begin
        sr_exl_reg    <= 1'b1;
        cause_bd_reg  <= bus.BDIn;
        cause_exc_reg <= int_req ? 5'd0 : bus.ExcCodeIn;
        epc_reg       <= epc_next;
      end else begin
        if (bus.en && bus.CP0Add == IDX_SR) begin
          sr_im_reg  <= bus.CP0In[15:10];
          sr_exl_reg <= bus.CP0In[1];
          sr_ie_reg  <= bus.CP0In[0];
        end
        if (bus.en && bus.CP0Add == IDX_EPC) begin
          epc_reg <= bus.CP0In & 32'hFFFF_FFFC;
        end
        // eret overrides an mtc0 to SR on the EXL bit only.
        if (bus.EXLClr) begin
          sr_exl_reg <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, mtc0, interrupt/exception entry, EXL masking, eret.
module tb_cp0_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    bus.CP0Add = addr;
    #1;
    chk(tag, bus.CP0Out, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = 1'b0; bus.CP0Add = 5'd0; bus.CP0In = 32'd0; bus.VPC = 32'd0;
    bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.EXLClr = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    bus.HWInt = 6'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    // reset state
    rd(5'd12, 32'h0, "reset_sr");
    rd(5'd13, 32'h0, "reset_cause");
    rd(5'd14, 32'h0, "reset_epc");
    chk("reset_req", {31'd0, bus.Req}, 32'd0);

    // mtc0 SR: old value visible before the edge, new one after
    bus.en = 1'b1; bus.CP0Add = 5'd12; bus.CP0In = 32'h0000_FC01;
    #1;
    chk("mtc0_sr_before", bus.CP0Out, 32'h0);
    tick();
    idle();
    rd(5'd12, 32'h0000_FC01, "mtc0_sr_after");

    // interrupt entry
    bus.HWInt = 6'b000100; bus.VPC = 32'h0000_3000;
    #1;
    chk("int_req_same_cycle", {31'd0, bus.Req}, 32'd1);
    tick();
    rd(5'd13, 32'h0000_1000, "int_cause");
    rd(5'd12, 32'h0000_FC03, "int_sr_exl");
    chk("int_epc", bus.EPCOut, 32'h0000_3000);
    chk("int_req_masked", {31'd0, bus.Req}, 32'd0);

    // EXL masks exception and interrupt; only IP tracks HWInt
    bus.ExcCodeIn = 5'd4; bus.HWInt = 6'b000001; bus.VPC = 32'h0000_5000;
    #1;
    chk("exl_mask_req", {31'd0, bus.Req}, 32'd0);
    tick();
    rd(5'd13, 32'h0000_0400, "exl_mask_cause");
    rd(5'd12, 32'h0000_FC03, "exl_mask_sr");
    chk("exl_mask_epc", bus.EPCOut, 32'h0000_3000);

    // eret with pending interrupt: Req rises on the following cycle
    bus.ExcCodeIn = 5'd0; bus.HWInt = 6'b000100; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0; bus.VPC = 32'h0000_3010;
    rd(5'd12, 32'h0000_FC01, "eret_sr");
    chk("eret_pending_req", {31'd0, bus.Req}, 32'd1);
    tick();
    chk("eret_reenter_epc", bus.EPCOut, 32'h0000_3010);
    bus.HWInt = 6'd0; bus.EXLClr = 1'b1;
    tick();
    idle();

    // exception in delay slot
    bus.ExcCodeIn = 5'd12; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3008;
    #1;
    chk("exc_req", {31'd0, bus.Req}, 32'd1);
    tick();
    idle();
    chk("exc_epc_bd", bus.EPCOut, 32'h0000_3004);
    rd(5'd13, 32'h8000_0030, "exc_cause_bd");

    // unimplemented index reads 0 and ignores writes
    bus.en = 1'b1; bus.CP0Add = 5'd5; bus.CP0In = 32'hDEAD_BEEF;
    tick();
    idle();
    rd(5'd5, 32'h0, "unimpl_read");

    // eret + mtc0 SR in same cycle: EXL ends 0, IM/IE taken
    bus.EXLClr = 1'b1; bus.en = 1'b1; bus.CP0Add = 5'd12; bus.CP0In = 32'h0000_0403;
    tick();
    idle();
    rd(5'd12, 32'h0000_0401, "eret_mtc0_prio");

    // interrupt wins over simultaneous exception; EPC low bits forced 0
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd8; bus.VPC = 32'h0000_3021;
    tick();
    idle();
    rd(5'd13, 32'h0000_0400, "int_over_exc_cause");
    chk("int_over_exc_epc", bus.EPCOut, 32'h0000_3020);

    // VPC-4 wraps
    bus.HWInt = 6'd0; bus.EXLClr = 1'b1;
    tick();
    idle();
    bus.ExcCodeIn = 5'd4; bus.BDIn = 1'b1; bus.VPC = 32'h0000_0002;
    tick();
    idle();
    chk("epc_wrap", bus.EPCOut, 32'hFFFF_FFFC);

    // mtc0 EPC with low bits set
    bus.en = 1'b1; bus.CP0Add = 5'd14; bus.CP0In = 32'h1234_5677;
    tick();
    idle();
    rd(5'd14, 32'h1234_5674, "mtc0_epc");

    // reset beats exception and mtc0 on the same edge
    bus.HWInt = 6'b111111; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    reset = 1'b1; bus.ExcCodeIn = 5'd4; bus.en = 1'b1; bus.CP0Add = 5'd12;
    bus.CP0In = 32'hFFFF_FFFF; bus.HWInt = 6'd0;
    tick();
    reset = 1'b0;
    idle();
    rd(5'd12, 32'h0, "rst_prio_sr");
    rd(5'd13, 32'h0, "rst_prio_cause");
    rd(5'd14, 32'h0, "rst_prio_epc");
    chk("rst_prio_req", {31'd0, bus.Req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
